// File: rtl/sample_frame_ctrl_pkg.sv
// Shared defaults and FSM state type for the ping-pong sample frame controller.
package sample_frame_ctrl_pkg;

  localparam int DATA_W_DEF    = 12;
  localparam int ADDR_W_DEF    = 7;
  localparam int FRAME_LEN_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/sample_frame_ctrl_ram.sv
// Sample RAM: one write port, one registered read port, contents not reset.
module sample_ram
  import sample_frame_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_frame_ctrl.sv
// Ping-pong frame controller: ADC fills one RAM bank while compute reads the
// other; banks swap at frame boundaries, with a stall/overrun path.
//
// state | meaning
// IDLE  | capture disarmed, ADC strobes ignored
// FILL  | writing samples into bank wb at wr_ptr
// STALL | bank wb full, waiting for compute to release its frame; samples dropped
module sample_frame_ctrl
  import sample_frame_ctrl_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture_en,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic              comp_rd_en,
  input  logic [ADDR_W-2:0] comp_rd_addr,
  output logic [DATA_W-1:0] comp_rd_data,
  output logic              comp_rd_valid,
  input  logic              comp_done,
  output logic              overrun,
  output logic              busy
);

  localparam int PTR_W = ADDR_W - 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FRAME_LEN - 1);

  fsm_state_t        state_q, state_d;
  logic              wb_q, wb_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              frame_ready_d, frame_bank_d, overrun_d;
  logic              publish;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wb_q          <= 1'b0;
      wr_ptr_q      <= '0;
      frame_ready   <= 1'b0;
      frame_bank    <= 1'b0;
      overrun       <= 1'b0;
      comp_rd_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      wb_q          <= wb_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_ready   <= frame_ready_d;
      frame_bank    <= frame_bank_d;
      overrun       <= overrun_d;
      comp_rd_valid <= ram_re;
    end
  end

  always_comb begin
    state_d       = state_q;
    wb_d          = wb_q;
    wr_ptr_d      = wr_ptr_q;
    frame_ready_d = frame_ready;
    frame_bank_d  = frame_bank;
    overrun_d     = overrun;
    publish       = 1'b0;
    ram_we        = 1'b0;

    case (state_q)
      IDLE: begin
        if (capture_en) begin
          state_d   = FILL;
          wr_ptr_d  = '0;
          overrun_d = 1'b0;
        end
      end
      FILL: begin
        if (!capture_en) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end else if (adc_valid) begin
          ram_we = 1'b1;
          if (wr_ptr_q != LAST_PTR) wr_ptr_d = wr_ptr_q + PTR_W'(1);
          else if (!frame_ready || comp_done) publish = 1'b1;
          else state_d = STALL;
        end
      end
      STALL: begin
        if (!capture_en) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end else begin
          // a strobe in the release cycle still lands in the stalled window
          if (adc_valid) overrun_d = 1'b1;
          if (comp_done) begin
            publish = 1'b1;
            state_d = FILL;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (publish) begin
      frame_ready_d = 1'b1;
      frame_bank_d  = wb_q;
      wb_d          = ~wb_q;
      wr_ptr_d      = '0;
    end else if (comp_done && frame_ready) begin
      frame_ready_d = 1'b0;
    end
  end

  assign ram_re       = comp_rd_en && frame_ready;
  assign comp_rd_data = comp_rd_valid ? ram_q : '0;
  assign busy         = (state_q != IDLE);

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr ({wb_q, wr_ptr_q}),
    .wr_data (adc_data),
    .rd_en   (ram_re),
    .rd_addr ({frame_bank, comp_rd_addr}),
    .rd_data (ram_q)
  );

endmodule

// File: tb/tb_sample_frame_ctrl.sv
// Self-checking bench for sample_frame_ctrl: vector table, directed frame
// sequences and randomized traffic against a queue-based frame model.
module tb_sample_frame_ctrl;

  localparam int FL = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en, adc_valid, comp_rd_en, comp_done;
  logic [11:0] adc_data;
  logic [5:0]  comp_rd_addr;
  logic        frame_ready, frame_bank, comp_rd_valid, overrun, busy;
  logic [11:0] comp_rd_data;

  int total = 0;
  int bad   = 0;

  // frame-level model
  bit          m_active, m_stalled, m_fr, m_ovr;
  int          m_pubs;
  logic [11:0] m_cur[$];
  logic [11:0] m_pub[FL];

  sample_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .capture_en    (capture_en),
    .adc_valid     (adc_valid),
    .adc_data      (adc_data),
    .frame_ready   (frame_ready),
    .frame_bank    (frame_bank),
    .comp_rd_en    (comp_rd_en),
    .comp_rd_addr  (comp_rd_addr),
    .comp_rd_data  (comp_rd_data),
    .comp_rd_valid (comp_rd_valid),
    .comp_done     (comp_done),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_fb();
    return (m_pubs == 0) ? 1'b0 : 1'((m_pubs - 1) % 2);
  endfunction

  task automatic model_reset();
    m_active = 0; m_stalled = 0; m_fr = 0; m_ovr = 0; m_pubs = 0;
    m_cur.delete();
  endtask

  task automatic model_publish();
    for (int i = 0; i < FL; i++) m_pub[i] = m_cur[i];
    m_cur.delete();
    m_pubs++;
  endtask

  task automatic step(input bit cap, input bit adc, input logic [11:0] d,
                      input bit done, input bit rd, input logic [5:0] a);
    bit          exp_rv, published;
    logic [11:0] exp_rd;
    capture_en = cap; adc_valid = adc; adc_data = d;
    comp_done = done; comp_rd_en = rd; comp_rd_addr = a;
    exp_rv = rd && m_fr;
    exp_rd = m_pub[a];
    published = 0;
    if (!m_active) begin
      if (cap) begin m_active = 1; m_ovr = 0; m_cur.delete(); end
    end else if (!cap) begin
      m_active = 0; m_stalled = 0; m_cur.delete();
    end else if (m_stalled) begin
      if (adc) m_ovr = 1;
      if (done) begin model_publish(); m_stalled = 0; published = 1; end
    end else if (adc) begin
      m_cur.push_back(d);
      if (m_cur.size() == FL) begin
        if (!m_fr || done) begin model_publish(); published = 1; end
        else m_stalled = 1;
      end
    end
    if (published) m_fr = 1;
    else if (done) m_fr = 0;
    @(posedge clk); #1;
    check("frame_ready", 32'(frame_ready), 32'(m_fr));
    check("frame_bank", 32'(frame_bank), 32'(m_fb()));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("busy", 32'(busy), 32'(m_active));
    check("rd_valid", 32'(comp_rd_valid), 32'(exp_rv));
    if (exp_rv) check("rd_data", 32'(comp_rd_data), 32'(exp_rd));
  endtask

  task automatic feed(input int n, input int base, input bit done_last);
    for (int i = 0; i < n; i++)
      step(1, 1, 12'(base + i), done_last && (i == n - 1), 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fr"}, 32'(frame_ready), 0);
    check({tag, "_fb"}, 32'(frame_bank), 0);
    check({tag, "_rdv"}, 32'(comp_rd_valid), 0);
    check({tag, "_rdd"}, 32'(comp_rd_data), 0);
    check({tag, "_ovr"}, 32'(overrun), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic do_reset();
    capture_en = 0; adc_valid = 0; adc_data = 0;
    comp_done = 0; comp_rd_en = 0; comp_rd_addr = 0;
    reset = 1;
    #12;
    check_reset_outputs("rst");
    reset = 0;
    model_reset();
  endtask

  typedef struct {
    bit cap, adc; logic [11:0] d; bit done, rd; logic [5:0] a;
    bit e_fr, e_busy, e_ovr, e_rv;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 1, 12'h005, 0, 0, 6'd0, 0, 0, 0, 0};
    vecs[1] = '{0, 0, 12'h000, 0, 1, 6'd3, 0, 0, 0, 0};
    vecs[2] = '{1, 1, 12'h007, 0, 0, 6'd0, 0, 1, 0, 0};
    vecs[3] = '{1, 0, 12'h000, 1, 1, 6'd0, 0, 1, 0, 0};
    vecs[4] = '{1, 1, 12'h009, 0, 0, 6'd0, 0, 1, 0, 0};
    vecs[5] = '{0, 0, 12'h000, 0, 0, 6'd0, 0, 0, 0, 0};
    vecs[6] = '{1, 0, 12'h000, 0, 0, 6'd0, 0, 1, 0, 0};
    vecs[7] = '{0, 1, 12'h011, 0, 1, 6'd1, 0, 0, 0, 0};

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].cap, vecs[i].adc, vecs[i].d, vecs[i].done, vecs[i].rd, vecs[i].a);
      check($sformatf("vec%0d_fr", i), 32'(frame_ready), 32'(vecs[i].e_fr));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
      check($sformatf("vec%0d_rv", i), 32'(comp_rd_valid), 32'(vecs[i].e_rv));
    end

    // first frame into bank 0
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    feed(FL, 1, 0);
    check("f1_ready", 32'(frame_ready), 1);
    check("f1_bank", 32'(frame_bank), 0);
    step(1, 0, 0, 0, 1, 6'd0);
    check("f1_rd0", 32'(comp_rd_data), 1);
    step(1, 0, 0, 0, 1, 6'd63);
    check("f1_rd63", 32'(comp_rd_data), 64);

    // second frame, release before its last sample
    feed(FL - 1, 101, 0);
    step(1, 0, 0, 1, 0, 0);
    check("f2_released", 32'(frame_ready), 0);
    feed(1, 164, 0);
    check("f2_ready", 32'(frame_ready), 1);
    check("f2_bank", 32'(frame_bank), 1);
    check("f2_ovr", 32'(overrun), 0);

    // third frame stalls, drops samples
    feed(FL, 201, 0);
    check("f3_stall_busy", 32'(busy), 1);
    check("f3_stall_bank", 32'(frame_bank), 1);
    check("f3_stall_ovr", 32'(overrun), 0);
    feed(5, 900, 0);
    check("f3_ovr", 32'(overrun), 1);
    step(1, 0, 0, 1, 0, 0);
    check("f3_bank", 32'(frame_bank), 0);
    check("f3_ready", 32'(frame_ready), 1);
    step(1, 0, 0, 0, 1, 6'd0);
    check("f3_rd0", 32'(comp_rd_data), 201);
    step(1, 0, 0, 0, 1, 6'd63);
    check("f3_rd63", 32'(comp_rd_data), 264);

    // release coinciding with last sample: direct swap
    feed(FL, 301, 1);
    check("f4_ready", 32'(frame_ready), 1);
    check("f4_bank", 32'(frame_bank), 1);
    check("f4_busy", 32'(busy), 1);

    // abort partial frame, re-arm
    feed(30, 401, 0);
    step(0, 0, 0, 0, 0, 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_ready", 32'(frame_ready), 1);
    check("abort_bank", 32'(frame_bank), 1);
    step(1, 0, 0, 0, 0, 0);
    check("rearm_ovr", 32'(overrun), 0);
    step(1, 0, 0, 1, 0, 0);
    feed(FL, 501, 0);
    check("f5_bank", 32'(frame_bank), 0);
    step(1, 0, 0, 0, 1, 6'd0);
    check("f5_rd0", 32'(comp_rd_data), 501);
    step(1, 0, 0, 0, 1, 6'd63);
    check("f5_rd63", 32'(comp_rd_data), 564);

    // stall, then asynchronous reset mid-cycle
    feed(FL, 601, 0);
    check("f6_stall_ready", 32'(frame_ready), 1);
    capture_en = 0; adc_valid = 0; comp_done = 0; comp_rd_en = 0;
    #2 reset = 1;
    #1 check_reset_outputs("async");
    #3 reset = 0;
    model_reset();
    step(0, 0, 0, 0, 1, 6'd5);
    check("post_rst_rv", 32'(comp_rd_valid), 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 999) < 997, $urandom_range(0, 99) < 70,
           12'($urandom), $urandom_range(0, 99) < 4,
           $urandom_range(0, 1) == 1, 6'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
